// File: rtl/alien_pkg.sv
// Shared encodings and playfield geometry for the alien fleet controller.
package alien_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MARCH_R   = 3'd1,
    MARCH_L   = 3'd2,
    DESC_TO_L = 3'd3,
    DESC_TO_R = 3'd4,
    CLEARED   = 3'd5,
    INVADED   = 3'd6
  } state_t;

  localparam logic [1:0] MODE_PLAY = 2'd2;

  localparam int LEFT_EDGE      = 5;
  localparam int RIGHT_EDGE     = 635;
  localparam int BARRIER_BOTTOM = 400;
  localparam int N_ALIENS_DEF   = 8;

endpackage

// File: rtl/alien_fleet_ctrl_frame_tick.sv
// One-clock frame tick on the first clock that the scan sits at pixel (0,0).
module frame_tick_detect (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  output logic       o_tick
);

  logic w_f;
  logic r_tick_prev;

  assign w_f = (i_x == 10'd0) && (i_y == 10'd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_tick_prev <= 1'b0;
    else          r_tick_prev <= w_f;
  end

  assign o_tick = w_f && !r_tick_prev;

endmodule

// File: rtl/alien_fleet_ctrl.sv
// Fleet march sequencer: step timer, edge bounce / descend, speed-up and
// terminal (cleared / invaded) detection.
//   state     | meaning
//   IDLE      | not playing; timer and sticky flags cleared
//   MARCH_R   | stepping right
//   MARCH_L   | stepping left
//   DESC_TO_L | next step descends, then march left
//   DESC_TO_R | next step descends, then march right
//   CLEARED   | all aliens destroyed; hold until mode leaves play
//   INVADED   | live alien reached bottom; hold until mode leaves play
module alien_fleet_ctrl
  import alien_pkg::*;
#(
  parameter int N_ALIENS    = N_ALIENS_DEF,
  parameter int BASE_PERIOD = 200,
  parameter int MIN_PERIOD  = 20,
  parameter int SPEEDUP     = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          mode,
  input  logic [9:0]          xCoord,
  input  logic [9:0]          yCoord,
  input  logic [N_ALIENS-1:0] alive,
  input  logic [N_ALIENS-1:0] at_left,
  input  logic [N_ALIENS-1:0] at_right,
  input  logic [N_ALIENS-1:0] at_bottom,
  output logic                move_left,
  output logic                move_right,
  output logic                move_down,
  output logic [10:0]         step_period,
  output logic [3:0]          alive_count,
  output logic                wave_cleared,
  output logic                invaded,
  output logic [2:0]          state
);

  logic        w_tick, w_l, w_r, w_b, w_step_due;
  logic [3:0]  w_alive_count;
  logic [15:0] w_kills, w_raw, w_period;

  state_t      r_state, w_state_nxt;
  logic [10:0] r_frame_cnt, w_cnt_nxt;
  logic        r_move_left, r_move_right, r_move_down;
  logic        w_move_left, w_move_right, w_move_down;
  logic        r_wave_cleared, r_invaded, w_clr_nxt, w_inv_nxt;

  frame_tick_detect u_tick (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_x     (xCoord),
    .i_y     (yCoord),
    .o_tick  (w_tick)
  );

  // Dead aliens never trigger a bounce or an invasion.
  assign w_l = |(alive & at_left);
  assign w_r = |(alive & at_right);
  assign w_b = |(alive & at_bottom);

  always_comb begin
    w_alive_count = '0;
    for (int i = 0; i < N_ALIENS; i++) w_alive_count = w_alive_count + 4'(alive[i]);
  end

  assign w_kills  = 16'(N_ALIENS) - 16'(w_alive_count);
  assign w_raw    = 16'(BASE_PERIOD) - 16'(SPEEDUP) * w_kills;
  assign w_period = ($signed(w_raw) < $signed(16'(MIN_PERIOD))) ? 16'(MIN_PERIOD) : w_raw;
  // Written as cnt+1 >= period so a shrunken period never underflows.
  assign w_step_due = ({5'd0, r_frame_cnt} + 16'd1) >= w_period;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_frame_cnt;
    w_move_left  = 1'b0;
    w_move_right = 1'b0;
    w_move_down  = 1'b0;
    w_clr_nxt    = r_wave_cleared;
    w_inv_nxt    = r_invaded;
    if (mode != MODE_PLAY) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_clr_nxt   = 1'b0;
      w_inv_nxt   = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = MARCH_R;
          w_cnt_nxt   = '0;
        end
        MARCH_R, MARCH_L, DESC_TO_L, DESC_TO_R: begin
          if (alive == '0) begin
            w_state_nxt = CLEARED;
            w_clr_nxt   = 1'b1;
          end else if (w_b) begin
            w_state_nxt = INVADED;
            w_inv_nxt   = 1'b1;
          end else if (w_tick) begin
            if (w_step_due) begin
              w_cnt_nxt = '0;
              case (r_state)
                MARCH_R:   if (w_r) w_state_nxt = DESC_TO_L; else w_move_right = 1'b1;
                MARCH_L:   if (w_l) w_state_nxt = DESC_TO_R; else w_move_left = 1'b1;
                DESC_TO_L: begin w_move_down = 1'b1; w_state_nxt = MARCH_L; end
                default:   begin w_move_down = 1'b1; w_state_nxt = MARCH_R; end
              endcase
            end else begin
              w_cnt_nxt = r_frame_cnt + 11'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_frame_cnt    <= '0;
      r_move_left    <= 1'b0;
      r_move_right   <= 1'b0;
      r_move_down    <= 1'b0;
      r_wave_cleared <= 1'b0;
      r_invaded      <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_frame_cnt    <= w_cnt_nxt;
      r_move_left    <= w_move_left;
      r_move_right   <= w_move_right;
      r_move_down    <= w_move_down;
      r_wave_cleared <= w_clr_nxt;
      r_invaded      <= w_inv_nxt;
    end
  end

  assign move_left    = r_move_left;
  assign move_right   = r_move_right;
  assign move_down    = r_move_down;
  assign step_period  = w_period[10:0];
  assign alive_count  = w_alive_count;
  assign wave_cleared = r_wave_cleared;
  assign invaded      = r_invaded;
  assign state        = r_state;

endmodule

// File: tb/tb_alien_fleet_ctrl.sv
// Scoreboard bench for alien_fleet_ctrl against a direction/phase reference model.
module tb_alien_fleet_ctrl;
  localparam int N = 4, BASE = 4, MINP = 2, SPD = 1;

  logic         clk = 1'b0, rst = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic [9:0]   xCoord = 10'd100, yCoord = 10'd100;
  logic [N-1:0] alive = '0, at_left = '0, at_right = '0, at_bottom = '0;
  logic         move_left, move_right, move_down, wave_cleared, invaded;
  logic [10:0]  step_period;
  logic [3:0]   alive_count;
  logic [2:0]   state;

  alien_fleet_ctrl #(.N_ALIENS(N), .BASE_PERIOD(BASE), .MIN_PERIOD(MINP), .SPEEDUP(SPD)) dut (
    .clk(clk), .rst(rst), .mode(mode), .xCoord(xCoord), .yCoord(yCoord),
    .alive(alive), .at_left(at_left), .at_right(at_right), .at_bottom(at_bottom),
    .move_left(move_left), .move_right(move_right), .move_down(move_down),
    .step_period(step_period), .alive_count(alive_count),
    .wave_cleared(wave_cleared), .invaded(invaded), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; int k; } exp_t;  // k: 0 left, 1 right, 2 down
  exp_t q[$];

  logic         s_rst = 1'b0;
  logic [1:0]   s_mode = 2'd0;
  logic [N-1:0] s_alive = '1, s_left = '0, s_right = '0, s_bottom = '0;

  // Reference model: phase 0 idle, 1 marching, 2 descending next, 3 cleared, 4 invaded
  int m_phase = 0, m_dir = 1, m_cnt = 0;
  bit m_prev = 0, m_clr = 0, m_inv = 0;
  int exp_state = 0, exp_period = BASE, exp_count = N;
  bit exp_clr = 0, exp_inv = 0, mon_en = 0;
  int hold = 3, gap = 3, pix = 0;
  bit rand_frames = 0;

  task automatic chk(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic int period_of(logic [N-1:0] a);
    int p;
    p = BASE - SPD * (N - $countones(a));
    return (p < MINP) ? MINP : p;
  endfunction

  task automatic model_eval();
    bit f, tk, l, r, b;
    int p;
    f  = (xCoord == 0) && (yCoord == 0);
    tk = f && !m_prev;
    l  = |(alive & at_left);
    r  = |(alive & at_right);
    b  = |(alive & at_bottom);
    p  = period_of(alive);
    exp_period = p;
    exp_count  = $countones(alive);
    if (!rst) begin
      m_phase = 0; m_cnt = 0; m_dir = 1; m_prev = 0; m_clr = 0; m_inv = 0;
      q.delete();
    end else begin
      m_prev = f;
      if (mode != 2'd2) begin
        m_phase = 0; m_cnt = 0; m_dir = 1; m_clr = 0; m_inv = 0;
      end else if (m_phase == 0) begin
        m_phase = 1; m_dir = 1; m_cnt = 0;
      end else if (m_phase == 1 || m_phase == 2) begin
        if (alive == '0) begin
          m_phase = 3; m_clr = 1;
        end else if (b) begin
          m_phase = 4; m_inv = 1;
        end else if (tk) begin
          if (m_cnt >= p - 1) begin
            m_cnt = 0;
            if (m_phase == 1) begin
              if ((m_dir > 0) ? r : l) m_phase = 2;
              else q.push_back('{cyc + 1, (m_dir > 0) ? 1 : 0});
            end else begin
              q.push_back('{cyc + 1, 2});
              m_phase = 1;
              m_dir = -m_dir;
            end
          end else m_cnt++;
        end
      end
    end
    case (m_phase)
      1:       exp_state = (m_dir > 0) ? 1 : 2;
      2:       exp_state = (m_dir > 0) ? 3 : 4;
      3:       exp_state = 5;
      4:       exp_state = 6;
      default: exp_state = 0;
    endcase
    exp_clr = m_clr;
    exp_inv = m_inv;
  endtask

  task automatic run_cyc();
    @(negedge clk);
    rst = s_rst; mode = s_mode; alive = s_alive;
    at_left = s_left; at_right = s_right; at_bottom = s_bottom;
    if (pix < hold) begin
      xCoord = 10'd0; yCoord = 10'd0;
    end else begin
      xCoord = 10'($urandom_range(0, 639));
      yCoord = 10'($urandom_range(1, 479));
    end
    pix++;
    if (pix >= hold + gap) begin
      pix = 0;
      if (rand_frames) begin
        hold = $urandom_range(1, 3);
        gap  = $urandom_range(1, 4);
      end
    end
    model_eval();
  endtask

  task automatic run_n(int n);
    for (int i = 0; i < n; i++) run_cyc();
  endtask

  task automatic run_until_desc(int budget);
    int n;
    n = 0;
    while (m_phase != 2 && n < budget) begin run_cyc(); n++; end
    if (m_phase != 2) chk("wait_desc_timeout", n, -1);
  endtask

  task automatic restart();
    s_mode = 2'd0; s_left = '0; s_right = '0; s_bottom = '0;
    run_n(3);
    s_mode = 2'd2;
  endtask

  // Monitor: compares every cycle and pops the scoreboard on each strobe.
  exp_t e;
  int   kind;
  always begin
    @(posedge clk);
    #1;
    if (mon_en) begin
      chk("state", int'(state), exp_state);
      chk("wave_cleared", int'(wave_cleared), int'(exp_clr));
      chk("invaded", int'(invaded), int'(exp_inv));
      chk("step_period", int'(step_period), exp_period);
      chk("alive_count", int'(alive_count), exp_count);
      chk("strobe_onehot", int'((int'(move_left) + int'(move_right) + int'(move_down)) <= 1), 1);
      if (move_left || move_right || move_down) begin
        kind = move_left ? 0 : (move_right ? 1 : 2);
        if (q.size() == 0) chk("unexpected_strobe", kind, -1);
        else begin
          e = q.pop_front();
          chk("strobe_kind", kind, e.k);
          chk("strobe_cycle", cyc, e.c);
        end
      end else if (q.size() > 0 && q[0].c <= cyc) begin
        e = q.pop_front();
        chk("missed_strobe", -1, e.k);
      end
    end
  end

  int n;
  initial begin
    #3;
    chk("rst_state", int'(state), 0);
    chk("rst_move", int'({move_left, move_right, move_down}), 0);
    chk("rst_flags", int'({wave_cleared, invaded}), 0);
    run_cyc();
    mon_en = 1;
    run_cyc();
    s_rst = 1'b1;

    // steady march right, (0,0) held 3 clocks per frame
    s_mode = 2'd2;
    run_n(150);

    // right-edge bounce on a live alien: descend then march left
    s_right = 4'b0010;
    run_until_desc(200);
    s_right = 4'b0000;
    run_n(80);

    // edge flag only on a dead alien is ignored
    restart();
    s_alive = 4'b1110; s_right = 4'b0001;
    run_n(60);

    // speed-up mid-count and clamp
    restart();
    s_alive = 4'b1111;
    run_n(15);
    s_alive = 4'b1100;
    run_n(60);
    s_alive = 4'b0001;
    run_n(40);

    // invasion while a descent is pending
    restart();
    s_alive = 4'b1111; s_right = 4'b0010;
    run_until_desc(200);
    s_right = 4'b0000; s_alive = 4'b0001; s_bottom = 4'b0001;
    run_n(30);
    s_mode = 2'd0;
    run_n(3);

    // cleared wins over invaded in the same cycle
    restart();
    s_alive = 4'b1111;
    run_n(10);
    s_alive = 4'b0000; s_bottom = 4'b0001;
    run_n(10);

    // asynchronous reset in the middle of a strobe cycle
    restart();
    s_alive = 4'b1111;
    n = 0;
    while (!(q.size() > 0 && q[q.size()-1].c == cyc + 1) && n < 300) begin run_cyc(); n++; end
    if (n >= 300) chk("wait_strobe_timeout", n, -1);
    else begin
      @(posedge clk);
      #2;
      rst = 1'b0; s_rst = 1'b0;
      #1;
      chk("async_rst_move", int'({move_left, move_right, move_down}), 0);
      chk("async_rst_state", int'(state), 0);
      chk("async_rst_flags", int'({wave_cleared, invaded}), 0);
    end
    s_rst = 1'b0;
    run_n(2);
    s_rst = 1'b1;
    run_n(60);

    // randomized play with kills, edges, rare invasions and mode drops
    rand_frames = 1;
    for (int rnd = 0; rnd < 10; rnd++) begin
      restart();
      s_alive = N'($urandom_range(1, 15));
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(0, 39) == 0) s_alive[$urandom_range(0, N-1)] = 1'b0;
        if ($urandom_range(0, 19) == 0) s_left  = N'($urandom);
        if ($urandom_range(0, 19) == 0) s_right = N'($urandom);
        if ($urandom_range(0, 399) == 0) s_bottom = N'($urandom_range(1, 15));
        s_mode = ($urandom_range(0, 299) == 0) ? 2'd0 : 2'd2;
        run_cyc();
      end
    end
    s_mode = 2'd0;
    run_n(5);
    chk("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alien_fleet_ctrl.md
Name: alien_fleet_ctrl

Overview:
Sequences the marching motion of the whole alien fleet. It owns the step timer, the left/right direction and the edge-bounce/descend decision, and drives one-cycle move_left/move_right/move_down strobes to every alien instance. It speeds the march up as aliens are destroyed, and flags wave-cleared and invasion (alien reached the bottom) to the top-level game FSM.

Parameters:
N_ALIENS, 8, number of alien instances controlled
BASE_PERIOD, 200, frames per step with the full fleet alive
MIN_PERIOD, 20, lower bound on frames per step
SPEEDUP, 20, frames removed from the period per destroyed alien

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
mode  input  2  game mode; 2 = playing, anything else = not playing
xCoord  input  10  VGA pixel x
yCoord  input  10  VGA pixel y
alive  input  N_ALIENS  per-alien alive flag
at_left  input  N_ALIENS  alien at left march limit
at_right  input  N_ALIENS  alien at right march limit
at_bottom  input  N_ALIENS  alien at barrier bottom
move_left  output  1  one-cycle step-left strobe
move_right  output  1  one-cycle step-right strobe
move_down  output  1  one-cycle step-down strobe
step_period  output  11  current frames-per-step
alive_count  output  4  popcount of alive
wave_cleared  output  1  sticky: all aliens destroyed
invaded  output  1  sticky: live alien reached bottom
state  output  3  FSM state, for debug/top-level

Behaviour:
- Reset (rst=0, async): state=IDLE; frame_cnt=0; dir=RIGHT; all strobes, wave_cleared and invaded are 0; tick_prev=0.
- Frame tick: f = (xCoord==0 && yCoord==0), registered into tick_prev. tick = f && !tick_prev, i.e. exactly one clk per frame however many clocks the pixel (0,0) lasts.
- Only alive aliens count: l = |(alive & at_left), r = |(alive & at_right), b = |(alive & at_bottom).
- alive_count: combinational popcount of alive.
- step_period:
  - kills = N_ALIENS - alive_count.
  - step_period = BASE_PERIOD - SPEEDUP*kills, computed in 16 bits, clamped to MIN_PERIOD if below it or negative. Combinational.
- States:
  - IDLE, MARCH_R, MARCH_L, DESC_TO_L, DESC_TO_R, CLEARED, INVADED.
  - DESC_* means the next step is a descent, after which the fleet marches in the named direction.
- IDLE:
  - Entered whenever mode!=2, from any state. frame_cnt, dir, wave_cleared and invaded are cleared there.
  - When mode==2: go to MARCH_R on the next clk.
- Step timer (MARCH_*/DESC_* only):
  - On each tick: if frame_cnt >= step_period-1, then step and frame_cnt<=0; else frame_cnt++.
  - A period shrink that leaves frame_cnt above the new limit causes a step on the next tick. No underflow.
- On a step (strobe is registered, high in the clk after the tick cycle, for exactly 1 clk):
  - MARCH_R: if r, go to DESC_TO_L with no strobe this step; else pulse move_right.
  - MARCH_L: if l, go to DESC_TO_R with no strobe; else pulse move_left.
  - DESC_TO_L / DESC_TO_R: if b, go to INVADED with no strobe; else pulse move_down and go to MARCH_L / MARCH_R respectively.
- At most one strobe is high in any cycle.
- Terminal checks, evaluated every clk in MARCH_*/DESC_*, with priority over stepping:
  - alive==0: go to CLEARED and set wave_cleared.
  - Else b in any state: go to INVADED and set invaded.
  - If both hold in the same cycle, CLEARED wins.
- CLEARED and INVADED hold with no strobes until mode!=2, which moves to IDLE.
- mode leaving 2 mid-step: any pending strobe is suppressed; the transition to IDLE takes effect on the same edge.

Decomposition:
- Package alien_pkg holds:
  - the state encoding (IDLE=0, MARCH_R=1, MARCH_L=2, DESC_TO_L=3, DESC_TO_R=4, CLEARED=5, INVADED=6);
  - MODE_PLAY=2;
  - shared geometry constants LEFT_EDGE=5, RIGHT_EDGE=635, BARRIER_BOTTOM=400;
  - default N_ALIENS.
- Sub-module frame_tick_detect: the rising-edge detector producing the 1-clk tick.

Test Plan:
Use N_ALIENS=4, BASE_PERIOD=4, MIN_PERIOD=2, SPEEDUP=1 throughout.
- 4 alive, no edges, mode=2, (0,0) held 3 clks per frame -> exactly one move_right pulse every 4 frames, each 1 clk wide, first pulse 1 clk after the 4th tick; never a double pulse.
- Right-edge bounce: alive=4'b1111, at_right=4'b0010 before the step -> no strobe on that step; next step gives move_down; following step gives move_left. Repeat with at_right set only on a dead alien -> move_right continues unchanged.
- Speed-up: alive drops 1111->1100 mid-count -> step_period=2 and alive_count=2; step_period clamps at 2 when alive=4'b0001.
- Invasion: in DESC_TO_L with at_bottom=4'b0001 and alive=4'b0001 -> invaded=1, state=INVADED, no further strobes; mode 2->0 -> IDLE with invaded=0.
- Same cycle alive=0 and at_bottom!=0 -> wave_cleared=1, invaded=0, state=CLEARED.
- rst pulled low asynchronously mid-period during a strobe cycle -> all outputs 0 immediately without waiting for a clk edge; after release, march restarts from MARCH_R with frame_cnt=0.
